// File: rtl/slc3_mem_responder.sv
// Purpose: SLC-3 style memory responder with a word RAM and one memory-mapped I/O word at 16'hFFFF (switch in, hex display out).
// Latency: mem_ready pulses RD_LATENCY cycles after the accepting edge, for both reads and writes.
// Backpressure: four-phase; a request is taken only in IDLE and the strobe must drop before another is accepted.
// Optional feature: define SLC3_MEM_BOUNDS_ERR_EN to flag/suppress RAM accesses with address bits above ADDR_WIDTH set.
module slc3_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic        mem_err
);

  localparam int          DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam logic [2:0]  CNT_INIT = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [15:0]             ram [DEPTH];

  // two-stage synchronizer for the asynchronous switch bank
  logic [15:0]             sw_meta;
  logic [15:0]             sw_sync;

  // request fields captured on the accepting edge; write data is not kept
  // because writes commit on that same edge
  logic                    lat_wr;
  logic                    lat_io;
  logic                    lat_oob;
  logic [ADDR_WIDTH-1:0]   lat_idx;

  // decode of the live request inputs (only meaningful while in IDLE)
  logic                    in_io;
  logic                    in_oob;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    accept;
  logic                    ram_we;

  // read source selection and the value loaded into mem_rdata
  logic                    rd_io;
  logic                    rd_oob;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [15:0]             rd_val;

  assign in_io  = (mem_addr == IO_ADDR);
  assign in_idx = mem_addr[ADDR_WIDTH-1:0];

`ifdef SLC3_MEM_BOUNDS_ERR_EN
  assign in_oob = !in_io && (mem_addr[15:ADDR_WIDTH] != '0);
`else
  // upper address bits simply alias onto the RAM
  assign in_oob = 1'b0;
`endif

  assign accept = (state == IDLE) && mem_mem_ena;

  // reset gates the write so a strobe held through reset cannot corrupt RAM
  assign ram_we = accept && mem_wr_ena && !in_io && !in_oob && !reset;

  // With RD_LATENCY=1 the read result is loaded on the accepting edge itself,
  // so the live inputs are used; otherwise the latched request is used.
  always_comb begin
    rd_io  = lat_io;
    rd_oob = lat_oob;
    rd_idx = lat_idx;
    if (state == IDLE) begin
      rd_io  = in_io;
      rd_oob = in_oob;
      rd_idx = in_idx;
    end
    if (rd_io) begin
      rd_val = sw_sync;
    end else if (rd_oob) begin
      rd_val = 16'h0000;
    end else begin
      rd_val = ram[rd_idx];
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[in_idx] <= mem_wdata;
    end
  end

  // switch input synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= 16'h0000;
      sw_sync <= 16'h0000;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
    end
  end

  // hex display register, loaded by an I/O write on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_o <= 16'h0000;
    end else if (accept && mem_wr_ena && in_io) begin
      hex_o <= mem_wdata;
    end
  end

`ifdef SLC3_MEM_BOUNDS_ERR_EN
  // sticky out-of-range flag, set by any accepted access beyond the RAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (accept && in_oob) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

  // handshake FSM: accept, count down the latency, pulse ready, wait for strobe low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 16'h0000;
      lat_wr    <= 1'b0;
      lat_io    <= 1'b0;
      lat_oob   <= 1'b0;
      lat_idx   <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_mem_ena) begin
            lat_wr  <= mem_wr_ena;
            lat_io  <= in_io;
            lat_oob <= in_oob;
            lat_idx <= in_idx;
            cnt     <= CNT_INIT;
            if (RD_LATENCY == 1) begin
              state     <= DONE;
              mem_ready <= 1'b1;
              if (!mem_wr_ena) begin
                mem_rdata <= rd_val;
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            if (!lat_wr) begin
              mem_rdata <= rd_val;
            end
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          // a strobe still held high must not start another request
          if (!mem_mem_ena) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder: three instances at RD_LATENCY 2, 1 and 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants for each scenario.
module tb_slc3_mem_responder;

  logic        clk;
  logic        reset;
  logic [2:0]  ena;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] sw;
  logic [2:0]  rdy;
  logic [15:0] rd0, rd1, rd4;
  logic [15:0] hex0, hex1, hex4;
  logic        err0, err1, err4;

  int pass_cnt;
  int total_cnt;

  slc3_mem_responder #(.ADDR_WIDTH(10), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_mem_ena(ena[0]), .mem_wr_ena(wr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rd0), .mem_ready(rdy[0]),
    .sw_i(sw), .hex_o(hex0), .mem_err(err0)
  );

  slc3_mem_responder #(.ADDR_WIDTH(10), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_mem_ena(ena[1]), .mem_wr_ena(wr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rd1), .mem_ready(rdy[1]),
    .sw_i(sw), .hex_o(hex1), .mem_err(err1)
  );

  slc3_mem_responder #(.ADDR_WIDTH(10), .RD_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .mem_mem_ena(ena[2]), .mem_wr_ena(wr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rd4), .mem_ready(rdy[2]),
    .sw_i(sw), .hex_o(hex4), .mem_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_rd(input int w);
    case (w)
      0:       return rd0;
      1:       return rd1;
      default: return rd4;
    endcase
  endfunction

  // One four-phase transaction on instance w. lat = falling edges from strobe
  // rise to first ready (-1 on timeout); extra = ready still high one cycle later.
  task automatic do_op(input int w, input logic is_wr, input logic [15:0] a,
                       input logic [15:0] d, output int lat,
                       output logic [15:0] rdv, output logic extra);
    lat   = -1;
    rdv   = 16'hxxxx;
    wr    = is_wr;
    addr  = a;
    wdata = d;
    ena[w] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy[w]) begin
        lat = k;
        rdv = get_rd(w);
        break;
      end
    end
    ena[w] = 1'b0;
    @(negedge clk);
    extra = rdy[w];
    @(negedge clk);
  endtask

  task automatic test_reset;
    int lat;
    reset = 1'b1;
    ena   = 3'b000;
    wr    = 1'b0;
    addr  = 16'h0000;
    wdata = 16'h0000;
    sw    = 16'h0000;
    repeat (3) @(negedge clk);
    total_cnt++; if (rdy[0] !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy[0]); else pass_cnt++;
    total_cnt++; if (rd0 !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rd0); else pass_cnt++;
    total_cnt++; if (hex0 !== 16'h0000) $display("FAIL reset_hex: got %h want 0000", hex0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL reset_err: got %b want 0", err0); else pass_cnt++;
    // strobe already high while reset releases: first IDLE edge accepts
    ena[0] = 1'b1;
    @(negedge clk);
    total_cnt++; if (rdy[0] !== 1'b0) $display("FAIL reset_held_ready: got %b want 0", rdy[0]); else pass_cnt++;
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy[0]) begin
        lat = k;
        break;
      end
    end
    ena[0] = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (lat !== 2) $display("FAIL reset_release_accept: latency %0d want 2", lat); else pass_cnt++;
  endtask

  task automatic test_write_read;
    int lat;
    logic [15:0] v;
    logic x;
    do_op(0, 1'b1, 16'h0010, 16'hBEEF, lat, v, x);
    total_cnt++; if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (x !== 1'b0) $display("FAIL wr_pulse_width: ready still %b want 0", x); else pass_cnt++;
    do_op(0, 1'b0, 16'h0010, 16'h0000, lat, v, x);
    total_cnt++; if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (v !== 16'hBEEF) $display("FAIL rd_data: got %h want beef", v); else pass_cnt++;
    // a write must leave mem_rdata as it was
    do_op(0, 1'b1, 16'h0020, 16'h1111, lat, v, x);
    total_cnt++; if (rd0 !== 16'hBEEF) $display("FAIL wr_keeps_rdata: got %h want beef", rd0); else pass_cnt++;
  endtask

  task automatic test_held_strobe;
    int lat;
    int pulses;
    logic [15:0] v;
    logic x;
    do_op(0, 1'b1, 16'h0003, 16'h0333, lat, v, x);
    wr = 1'b0;
    addr = 16'h0003;
    ena[0] = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[0]) pulses++;
    end
    total_cnt++; if (pulses !== 1) $display("FAIL held_one_pulse: got %0d pulses want 1", pulses); else pass_cnt++;
    total_cnt++; if (rd0 !== 16'h0333) $display("FAIL held_data: got %h want 0333", rd0); else pass_cnt++;
    ena[0] = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy[0]) pulses++;
    end
    total_cnt++; if (pulses !== 0) $display("FAIL held_low_quiet: got %0d pulses want 0", pulses); else pass_cnt++;
    ena[0] = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[0]) pulses++;
    end
    ena[0] = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (pulses !== 1) $display("FAIL held_retrigger: got %0d pulses want 1", pulses); else pass_cnt++;
  endtask

  task automatic test_io;
    int lat;
    logic [15:0] v;
    logic x;
    do_op(0, 1'b1, 16'h03FF, 16'hCAFE, lat, v, x);
    sw = 16'h1234;
    repeat (3) @(negedge clk);
    do_op(0, 1'b0, 16'hFFFF, 16'h0000, lat, v, x);
    total_cnt++; if (v !== 16'h1234) $display("FAIL io_read: got %h want 1234", v); else pass_cnt++;
    do_op(0, 1'b1, 16'hFFFF, 16'h00A5, lat, v, x);
    total_cnt++; if (hex0 !== 16'h00A5) $display("FAIL io_write_hex: got %h want 00a5", hex0); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL io_write_latency: got %0d want 2", lat); else pass_cnt++;
    do_op(0, 1'b0, 16'h03FF, 16'h0000, lat, v, x);
    total_cnt++; if (v !== 16'hCAFE) $display("FAIL io_ram_untouched: got %h want cafe", v); else pass_cnt++;
  endtask

  task automatic test_bounds;
    int lat;
    logic [15:0] v;
    logic x;
    logic [15:0] exp_low;
    logic [15:0] exp_high;
    logic        exp_err;
`ifdef SLC3_MEM_BOUNDS_ERR_EN
    exp_low  = 16'h1111;
    exp_high = 16'h0000;
    exp_err  = 1'b1;
`else
    exp_low  = 16'h5555;
    exp_high = 16'h5555;
    exp_err  = 1'b0;
`endif
    do_op(0, 1'b1, 16'h0001, 16'h1111, lat, v, x);
    do_op(0, 1'b1, 16'h0401, 16'h5555, lat, v, x);
    total_cnt++; if (lat !== 2) $display("FAIL bounds_wr_latency: got %0d want 2", lat); else pass_cnt++;
    do_op(0, 1'b0, 16'h0001, 16'h0000, lat, v, x);
    total_cnt++; if (v !== exp_low) $display("FAIL bounds_low_read: got %h want %h", v, exp_low); else pass_cnt++;
    do_op(0, 1'b0, 16'h0401, 16'h0000, lat, v, x);
    total_cnt++; if (v !== exp_high) $display("FAIL bounds_high_read: got %h want %h", v, exp_high); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL bounds_rd_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (err0 !== exp_err) $display("FAIL bounds_err: got %b want %b", err0, exp_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    logic [15:0] v;
    logic x;
    do_op(0, 1'b1, 16'h0005, 16'h5A5A, lat, v, x);
    do_op(0, 1'b0, 16'h0005, 16'h0000, lat, v, x);
    total_cnt++; if (v !== 16'h5A5A) $display("FAIL mid_preread: got %h want 5a5a", v); else pass_cnt++;
    wr = 1'b0;
    addr = 16'h0005;
    ena[0] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    ena[0] = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy[0]) pulses++;
    end
    total_cnt++; if (pulses !== 0) $display("FAIL mid_no_ready: got %0d pulses want 0", pulses); else pass_cnt++;
    total_cnt++; if (rd0 !== 16'h0000) $display("FAIL mid_rdata: got %h want 0000", rd0); else pass_cnt++;
    total_cnt++; if (hex0 !== 16'h0000) $display("FAIL mid_hex: got %h want 0000", hex0); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    do_op(0, 1'b0, 16'h0005, 16'h0000, lat, v, x);
    total_cnt++; if (lat !== 2) $display("FAIL mid_next_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (v !== 16'h5A5A) $display("FAIL mid_write_persists: got %h want 5a5a", v); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int exp_lat;
    logic [15:0] v;
    logic [15:0] d;
    logic x;
    for (int w = 1; w <= 2; w++) begin
      exp_lat = (w == 1) ? 1 : 4;
      for (int i = 0; i < 3; i++) begin
        d = 16'hA000 + 16'(i * 16'h0111) + 16'(w);
        do_op(w, 1'b1, 16'h0020 + 16'(i), d, lat, v, x);
        total_cnt++; if (lat !== exp_lat) $display("FAIL b2b_wr_lat_w%0d_i%0d: got %0d want %0d", w, i, lat, exp_lat); else pass_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
        d = 16'hA000 + 16'(i * 16'h0111) + 16'(w);
        do_op(w, 1'b0, 16'h0020 + 16'(i), 16'h0000, lat, v, x);
        total_cnt++; if (lat !== exp_lat) $display("FAIL b2b_rd_lat_w%0d_i%0d: got %0d want %0d", w, i, lat, exp_lat); else pass_cnt++;
        total_cnt++; if (v !== d) $display("FAIL b2b_rd_data_w%0d_i%0d: got %h want %h", w, i, v, d); else pass_cnt++;
        total_cnt++; if (x !== 1'b0) $display("FAIL b2b_pulse_w%0d_i%0d: ready still %b want 0", w, i, x); else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_write_read();
    test_held_strobe();
    test_io();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/slc3_mem_responder.md
SLC3_MEM_RESPONDER -- requirements
Module: slc3_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM depth 2**ADDR_WIDTH 16-bit words; legal range 4..15.
REQ-002 SHALL have parameter RD_LATENCY, default 2, cycles from request acceptance to mem_ready; legal range 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_mem_ena  input  1  request strobe from the CPU, level-held.
REQ-006 SHALL have port mem_wr_ena  input  1  1 = write, 0 = read; sampled with mem_mem_ena.
REQ-007 SHALL have port mem_addr  input  16  word address.
REQ-008 SHALL have port mem_wdata  input  16  write data.
REQ-009 SHALL have port mem_rdata  output  16  read data; valid from the mem_ready cycle until the next read completes.
REQ-010 SHALL have port mem_ready  output  1  single-cycle completion pulse.
REQ-011 SHALL have port sw_i  input  16  asynchronous switch inputs.
REQ-012 SHALL have port hex_o  output  16  registered hex-display value.
REQ-013 SHALL have port mem_err  output  1  sticky out-of-range flag; tied 0 unless SLC3_MEM_BOUNDS_ERR_EN is defined.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY, DONE, HOLD.
REQ-015 IDLE: mem_mem_ena=1 sampled at an edge SHALL accept the request, latch addr/wdata/wr, load the latency counter with RD_LATENCY-1, and go to BUSY (or DONE if RD_LATENCY=1).
REQ-016 BUSY SHALL decrement the counter each cycle and go to DONE when it reaches 0, so mem_ready is high exactly RD_LATENCY cycles after the accepting edge.
REQ-017 DONE SHALL assert mem_ready for exactly one cycle, then go to HOLD.
REQ-018 HOLD SHALL wait for mem_mem_ena=0 and then return to IDLE; a held strobe SHALL never retrigger a request (four-phase handshake).
REQ-019 Input changes on mem_mem_ena/addr/wdata/wr in BUSY, DONE or HOLD SHALL be ignored.
REQ-020 Decode SHALL use the latched address: 16'hFFFF is I/O; everything else is RAM at index addr[ADDR_WIDTH-1:0], with upper bits aliasing (wrap-around).
REQ-021 RAM write SHALL commit on the accepting edge; a read accepted in the following IDLE SHALL return the new data.
REQ-022 RAM read SHALL load mem_rdata from the latched index on the edge entering DONE.
REQ-023 I/O read SHALL return sw_i after a two-flop synchronizer; I/O write SHALL load hex_o on the accepting edge and SHALL NOT touch RAM.
REQ-024 Writes SHALL leave mem_rdata unchanged.

Reset
REQ-025 While reset is asserted, the block SHALL hold: state IDLE, counter 0, mem_ready 0, mem_rdata 16'h0000, hex_o 16'h0000, mem_err 0, synchronizer flops 0; RAM contents are not reset.
REQ-026 Reset mid-operation SHALL discard the in-flight read with no mem_ready; a write already committed SHALL persist.
REQ-027 After reset deasserts with mem_mem_ena already high, the first edge in IDLE SHALL accept the request.

Configuration
REQ-028 With SLC3_MEM_BOUNDS_ERR_EN defined, a non-I/O address with any of bits [15:ADDR_WIDTH] set SHALL set mem_err (sticky until reset), suppress the write, and read 16'h0000; handshake timing SHALL be unchanged.
REQ-029 Without SLC3_MEM_BOUNDS_ERR_EN, such addresses SHALL alias per REQ-020 and mem_err SHALL be constant 0.

Verification
REQ-030 RD_LATENCY=2: write 16'hBEEF to 16'h0010, drop the strobe, then read 16'h0010 -> mem_ready 2 cycles after each accept; the read returns 16'hBEEF.
REQ-031 Hold mem_mem_ena high 6 cycles on a read of 16'h0003 -> exactly one mem_ready pulse; a second pulse appears only after the strobe goes low and then high again.
REQ-032 sw_i=16'h1234, read 16'hFFFF -> mem_rdata=16'h1234; write 16'h00A5 to 16'hFFFF -> hex_o=16'h00A5, RAM index 16'h3FF unchanged.
REQ-033 Without the macro, ADDR_WIDTH=10: write 16'h5555 to 16'h0401, then read 16'h0001 -> 16'h5555, mem_err=0; with the macro -> read 16'h0000, mem_err=1, RAM[1] unchanged.
REQ-034 Assert reset one cycle after a read is accepted -> no mem_ready pulse, mem_rdata=16'h0000, state IDLE; the next read completes normally.
REQ-035 RD_LATENCY=1 and RD_LATENCY=4 with back-to-back four-phase reads -> mem_ready at +1 and +4 cycles respectively, with no dropped requests.
